// File: rtl/dmem_bridge.sv
// dmem_bridge
// ---------------------------------------------------------------------------
// Bridges a CPU data-memory access (word / half / byte, load or store) onto a
// private word-organised RAM. The CPU address is rebased by BASE_ADDR. The
// bridge checks the access for range and alignment errors, inserts
// WAIT_CYCLES wait states, and then signals completion with a one-cycle
// ready strobe. An address error completes one cycle after accept, with exc
// set and an exception cause code.
//
// Ports
//   clk    : single clock; all state changes on the rising edge
//   rst    : asynchronous, active-low reset
//   req    : access request, sampled only while idle
//   we     : 1 = store, 0 = load
//   w      : access size: 00 word, 01 half, 10 byte, 11 reserved (error)
//   addr   : CPU byte address before rebasing
//   wdata  : store data, right-justified for half/byte
//   rdata  : load data, right-justified and zero-extended; held until the
//            next completion
//   ready  : one-cycle completion strobe
//   busy   : high from the cycle after accept through the ready cycle
//   exc    : one-cycle address-error strobe, coincident with ready
//   cause  : 6'h10 load error, 6'h14 store error, 0 otherwise
// ---------------------------------------------------------------------------
module dmem_bridge #(
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int          DEPTH_WORDS = 2048,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        exc,
  output logic [5:0]  cause
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [2:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [2:0]      wait_cnt_reg, wait_cnt_next;

  // Access captured at accept time
  logic            we_reg;
  logic [1:0]      w_reg;
  logic [1:0]      lane_reg;
  logic [AW-1:0]   idx_reg;
  logic [31:0]     wdata_reg;
  logic [31:0]     rdata_hold_reg;

  logic [31:0]     offset;
  logic [AW-1:0]   idx_in;
  logic            addr_err;
  logic            accept;

  logic [7:0]      rd_lane [4];
  logic [31:0]     rd_word;
  logic [31:0]     ld_word;
  logic [31:0]     ld_shift;
  logic [31:0]     wr_word;
  logic [3:0]      wr_be;

  assign offset = addr - BASE_ADDR;
  assign idx_in = offset[AW+1:2];
  assign accept = (state_reg == IDLE) && req;

  // Anything at or beyond 4*DEPTH_WORDS shows up as a set bit above the
  // index field. That includes addresses below BASE_ADDR, which wrap to huge
  // offsets.
  always_comb begin
    addr_err = 1'b0;
    if (offset[31:AW+2] != '0) addr_err = 1'b1;
    case (w)
      2'b00:   if (offset[1:0] != 2'b00) addr_err = 1'b1;
      2'b01:   if (offset[0]) addr_err = 1'b1;
      2'b10:   ;
      default: addr_err = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (addr_err) begin
            state_next = ERR;
          end else if (WAIT_CYCLES > 0) begin
            state_next    = WAIT;
            wait_cnt_next = WAIT_INIT;
          end else begin
            state_next = DONE;
          end
        end
      end
      WAIT: begin
        if (wait_cnt_reg == 3'd0) state_next = DONE;
        else                      wait_cnt_next = wait_cnt_reg - 3'd1;
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      wait_cnt_reg   <= 3'd0;
      we_reg         <= 1'b0;
      w_reg          <= 2'b00;
      lane_reg       <= 2'b00;
      idx_reg        <= '0;
      wdata_reg      <= 32'd0;
      rdata_hold_reg <= 32'd0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (accept) begin
        we_reg    <= we;
        w_reg     <= w;
        lane_reg  <= offset[1:0];
        idx_reg   <= idx_in;
        wdata_reg <= wdata;
      end
      if (state_reg == DONE && !we_reg) rdata_hold_reg <= ld_word;
      else if (state_reg == ERR)        rdata_hold_reg <= 32'd0;
    end
  end

  // ---------------------------------------------------------------------
  // Store lane steering: replicate the right-justified data across the
  // word and let the byte enables pick the addressed lanes.
  // ---------------------------------------------------------------------
  always_comb begin
    wr_word = wdata_reg;
    wr_be   = 4'b1111;
    case (w_reg)
      2'b01: begin
        wr_word = {2{wdata_reg[15:0]}};
        wr_be   = lane_reg[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        wr_word = {4{wdata_reg[7:0]}};
        wr_be   = 4'b0001 << lane_reg;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Storage: one byte-wide RAM per lane, so that partial stores need no
  // read-modify-write. The read is launched on the accept edge, so data is
  // ready even with zero wait states. The write commits on the DONE edge.
  // A reset before that edge returns the FSM to IDLE and blocks the write.
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (state_reg == DONE && we_reg && wr_be[gi])
        lane_mem[idx_reg] <= wr_word[gi*8 +: 8];
      if (accept)
        rd_lane[gi] <= lane_mem[idx_in];
    end
  end

  assign rd_word  = {rd_lane[3], rd_lane[2], rd_lane[1], rd_lane[0]};
  assign ld_shift = rd_word >> {lane_reg, 3'b000};

  always_comb begin
    ld_word = rd_word;
    case (w_reg)
      2'b01:   ld_word = {16'd0, lane_reg[1] ? rd_word[31:16] : rd_word[15:0]};
      2'b10:   ld_word = {24'd0, ld_shift[7:0]};
      2'b11:   ld_word = 32'd0;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs decode straight from state, so reset clears them immediately.
  // ---------------------------------------------------------------------
  always_comb begin
    ready = (state_reg == DONE) || (state_reg == ERR);
    busy  = (state_reg != IDLE);
    exc   = (state_reg == ERR);
    cause = 6'h00;
    if (state_reg == ERR) cause = we_reg ? 6'h14 : 6'h10;
    rdata = rdata_hold_reg;
    if (state_reg == DONE && !we_reg) rdata = ld_word;
    else if (state_reg == ERR)        rdata = 32'd0;
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge. The stimulus tasks push the expected
// completion of each access. An independent monitor pops an entry on every
// ready strobe and compares rdata, exc, cause and latency. Three extra
// instances with WAIT_CYCLES of 0, 3 and 7 run with req held high. Their
// monitors check the spacing between ready strobes and the busy profile.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  w;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        exc;
  logic [5:0]  cause;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_bridge #(
    .BASE_ADDR  (32'h10010000),
    .DEPTH_WORDS(2048),
    .WAIT_CYCLES(1)
  ) u_dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .we   (we),
    .w    (w),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata),
    .ready(ready),
    .busy (busy),
    .exc  (exc),
    .cause(cause)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ------------------------------------------------------------------
  // Scoreboard and monitor
  // ------------------------------------------------------------------
  typedef struct {
    string       name;
    logic        chk_data;
    logic [31:0] rdata;
    logic        exc;
    logic [5:0]  cause;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  logic busy_q    = 1'b0;
  int   start_cyc = 0;

  // busy rises on the first cycle after the accept edge, so the accept edge
  // is start_cyc. Latency counts edges from accept to the edge that samples
  // ready.
  always @(negedge clk) begin
    if (busy && !busy_q) start_cyc = cyc;
    busy_q = busy;
    if (ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: ready=1 expected 0");
      end else begin
        e_mon = sb.pop_front();
        check({e_mon.name, "_exc"},   32'(exc),   32'(e_mon.exc));
        check({e_mon.name, "_cause"}, 32'(cause), 32'(e_mon.cause));
        check({e_mon.name, "_lat"},   32'(cyc - start_cyc + 1), 32'(e_mon.lat));
        if (e_mon.chk_data) check({e_mon.name, "_rdata"}, rdata, e_mon.rdata);
        $display("txn %-14s rdata=%h exc=%b cause=%h lat=%0d",
                 e_mon.name, rdata, exc, cause, cyc - start_cyc + 1);
      end
    end
  end

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  task automatic acc(input string name, input logic st, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] d, input logic chk,
                     input logic [31:0] er, input logic ex, input logic [5:0] ca,
                     input int lat, input logic push);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s_idle_timeout: busy=1 expected 0", name);
    end
    req   = 1'b1;
    we    = st;
    w     = sz;
    addr  = a;
    wdata = d;
    e.name = name; e.chk_data = chk; e.rdata = er;
    e.exc = ex; e.cause = ca; e.lat = lat;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    // Garbage while busy; the bridge must ignore it.
    req   = 1'b0;
    addr  = 32'hFFFF_FFF1;
    wdata = 32'h0BAD_0BAD;
  endtask

  task automatic st_ok(input string name, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    acc(name, 1'b1, sz, a, d, 1'b0, 32'd0, 1'b0, 6'h00, 2, 1'b1);
  endtask

  task automatic ld_ok(input string name, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] exp);
    acc(name, 1'b0, sz, a, 32'd0, 1'b1, exp, 1'b0, 6'h00, 2, 1'b1);
  endtask

  task automatic bad(input string name, input logic st, input logic [1:0] sz, input logic [31:0] a);
    acc(name, st, sz, a, 32'h5555AAAA, 1'b1, 32'd0, 1'b1, st ? 6'h14 : 6'h10, 1, 1'b1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: pending=%0d expected 0", name, sb.size());
    end
  endtask

  // ------------------------------------------------------------------
  // Wait-state sweep instances (continuous req)
  // ------------------------------------------------------------------
  logic        sw_req = 1'b0;
  logic        sw_on  = 1'b0;
  logic [31:0] sw_rdata [3];
  logic        sw_ready [3];
  logic        sw_busy  [3];
  logic        sw_exc   [3];
  logic [5:0]  sw_cause [3];
  int          sw_nrdy  [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    localparam int WC = (gi == 0) ? 0 : (gi == 1) ? 3 : 7;
    int last_rdy = 0;
    int hi_cnt   = 0;

    dmem_bridge #(
      .BASE_ADDR  (32'h10010000),
      .DEPTH_WORDS(2048),
      .WAIT_CYCLES(WC)
    ) u_sw (
      .clk  (clk),
      .rst  (rst),
      .req  (sw_req),
      .we   (1'b0),
      .w    (2'b00),
      .addr (32'h10010000),
      .wdata(32'd0),
      .rdata(sw_rdata[gi]),
      .ready(sw_ready[gi]),
      .busy (sw_busy[gi]),
      .exc  (sw_exc[gi]),
      .cause(sw_cause[gi])
    );

    initial sw_nrdy[gi] = 0;

    // Between two ready strobes: one idle/accept cycle, then WC busy cycles
    // before the next ready cycle.
    always @(negedge clk) begin
      if (sw_on && sw_ready[gi]) begin
        check($sformatf("sweep%0d_exc", WC), 32'(sw_exc[gi]), 32'd0);
        if (sw_nrdy[gi] > 0) begin
          check($sformatf("sweep%0d_spacing", WC), 32'(cyc - last_rdy), 32'(WC + 2));
          check($sformatf("sweep%0d_busy_run", WC), 32'(hi_cnt), 32'(WC));
        end
        $display("txn sweep%0d ready at cycle %0d", WC, cyc);
        sw_nrdy[gi] = sw_nrdy[gi] + 1;
        last_rdy    = cyc;
        hi_cnt      = 0;
      end else if (sw_on && sw_busy[gi]) begin
        hi_cnt++;
      end
    end
  end

  // ------------------------------------------------------------------
  // Main sequence
  // ------------------------------------------------------------------
  initial begin
    rst   = 1'b1;
    req   = 1'b0;
    we    = 1'b0;
    w     = 2'b00;
    addr  = 32'd0;
    wdata = 32'd0;
    #3 rst = 1'b0;
    #1;
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_busy",  32'(busy),  32'd0);
    check("reset_exc",   32'(exc),   32'd0);
    check("reset_cause", 32'(cause), 32'd0);
    check("reset_rdata", rdata,      32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    st_ok("st_word",     2'b00, 32'h10010008, 32'hDEADBEEF);
    ld_ok("ld_word",     2'b00, 32'h10010008, 32'hDEADBEEF);
    st_ok("st_base",     2'b00, 32'h10010008, 32'h11223344);
    st_ok("st_byte3",    2'b10, 32'h1001000B, 32'hFFFFFF5A);
    ld_ok("ld_merged",   2'b00, 32'h10010008, 32'h5A223344);
    ld_ok("ld_half_hi",  2'b01, 32'h1001000A, 32'h00005A22);
    ld_ok("ld_byte1",    2'b10, 32'h10010009, 32'h00000033);
    ld_ok("ld_half_lo",  2'b01, 32'h10010008, 32'h00003344);
    bad  ("ld_misalign", 1'b0, 2'b00, 32'h10010006);
    st_ok("st_w0",       2'b00, 32'h10010000, 32'hCAFEF00D);
    bad  ("st_half_odd", 1'b1, 2'b01, 32'h10010003);
    ld_ok("ld_w0_kept",  2'b00, 32'h10010000, 32'hCAFEF00D);
    st_ok("st_last",     2'b00, 32'h10011FFC, 32'hA5A5A5A5);
    bad  ("st_above",    1'b1, 2'b00, 32'h10012000);
    bad  ("st_below",    1'b1, 2'b00, 32'h1000FFFC);
    ld_ok("ld_w0_kept2", 2'b00, 32'h10010000, 32'hCAFEF00D);
    ld_ok("ld_last",     2'b00, 32'h10011FFC, 32'hA5A5A5A5);
    bad  ("ld_resv",     1'b0, 2'b11, 32'h10010000);
    st_ok("st_zero",     2'b00, 32'h1001000C, 32'h00000000);
    st_ok("st_half_hi",  2'b01, 32'h1001000E, 32'h1234BEEF);
    st_ok("st_byte1",    2'b10, 32'h1001000D, 32'hABCDEF77);
    ld_ok("ld_mix",      2'b00, 32'h1001000C, 32'hBEEF7700);
    ld_ok("ld_byte1b",   2'b10, 32'h1001000D, 32'h00000077);
    ld_ok("ld_byte3",    2'b10, 32'h1001000F, 32'h000000BE);

    // Reset while a store sits in WAIT: outputs clear at once, no write.
    st_ok("rst_pre",     2'b00, 32'h10010010, 32'h12345678);
    ld_ok("rst_pre_ld",  2'b00, 32'h10010010, 32'h12345678);
    acc("rst_abort", 1'b1, 2'b00, 32'h10010010, 32'h0000FFFF,
        1'b0, 32'd0, 1'b0, 6'h00, 2, 1'b0);
    #1 rst = 1'b0;
    #1;
    check("abort_ready", 32'(ready), 32'd0);
    check("abort_busy",  32'(busy),  32'd0);
    check("abort_exc",   32'(exc),   32'd0);
    check("abort_cause", 32'(cause), 32'd0);
    check("abort_rdata", rdata,      32'd0);
    @(negedge clk);
    rst = 1'b1;
    ld_ok("rst_post_ld", 2'b00, 32'h10010010, 32'h12345678);
    drain("main");

    // Wait-state sweep.
    @(posedge clk);
    #1;
    sw_on  = 1'b1;
    sw_req = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    sw_req = 1'b0;
    sw_on  = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sw_nrdy[i] < 5) begin
        errors++;
        $display("FAIL sweep_count%0d: got %0d expected at least 5", i, sw_nrdy[i]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule
